// File: rtl/ts_timer_pkg.sv
// Shared types and helpers for the microsecond timer scheduler.
package ts_timer_pkg;

   localparam int TS_W = 24;
   localparam logic [TS_W-1:0] MAX_DELAY = 24'h7FFFFF;
   localparam logic [TS_W-1:0] HALF_RANGE = 24'h800000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      PENDING = 2'd2
   } slot_state_t;

   // A deadline has been reached when now - deadline (mod 2^24) lies in the
   // lower half of the range. This stays correct across the timestamp wrap
   // for any delay up to MAX_DELAY.
   function automatic logic ts_expired(input logic [TS_W-1:0] now,
                                       input logic [TS_W-1:0] deadline);
      return (now - deadline) < HALF_RANGE;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            grant_any
);

   logic [ID_W-1:0] cand;

   // Scan from ptr upward with wrap and keep the first active request.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // one unassigned, which would otherwise infer a latch.
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = ID_W'((int'(ptr) + i) % N);
         if (!grant_any && req[cand]) begin
            grant_any   = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ts_timer_scheduler.sv
// Timer scheduler: NUM_SLOTS one-shot timers on a shared 24-bit microsecond
// timestamp, expiries delivered one at a time through a valid/ready register.
// Define TS_TIMER_PERIODIC_EN to add periodic slots with overrun flags.
module ts_timer_scheduler #(
   parameter int NUM_SLOTS = 4,
   parameter logic [23:0] MAX_DELAY = ts_timer_pkg::MAX_DELAY,
   localparam int ID_W = $clog2(NUM_SLOTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [23:0]          timestamp,
   input  logic                 arm_valid,
   output logic                 arm_ready,
   input  logic [ID_W-1:0]      arm_id,
   input  logic [23:0]          arm_delay,
`ifdef TS_TIMER_PERIODIC_EN
   input  logic                 arm_periodic,
   output logic [NUM_SLOTS-1:0] overrun,
`endif
   input  logic                 cancel_valid,
   input  logic [ID_W-1:0]      cancel_id,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [ID_W-1:0]      evt_id,
   output logic [23:0]          evt_timestamp,
   output logic [NUM_SLOTS-1:0] busy
);

   import ts_timer_pkg::*;

   slot_state_t          state    [NUM_SLOTS];
   logic [TS_W-1:0]      deadline [NUM_SLOTS];
   logic [TS_W-1:0]      exp_ts   [NUM_SLOTS];
   logic [ID_W-1:0]      rr_ptr;
   logic [NUM_SLOTS-1:0] req;
   logic [NUM_SLOTS-1:0] grant;
   logic [ID_W-1:0]      win_idx;
   logic                 win_any;
   logic                 take;
   logic [TS_W-1:0]      delay_c;

`ifdef TS_TIMER_PERIODIC_EN
   logic                 periodic [NUM_SLOTS];
   logic [TS_W-1:0]      period   [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] pend;
   logic [NUM_SLOTS-1:0] overrun_q;
   assign overrun = overrun_q;
`endif

   assign arm_ready = !rst;
   assign delay_c   = (arm_delay > MAX_DELAY) ? MAX_DELAY : arm_delay;
   // The output register can take a new event when empty or being drained.
   assign take      = (!evt_valid || evt_ready) && win_any;

   // Build the arbiter request vector and the per-slot busy flags.
   always_comb begin
      req  = '0;
      busy = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         busy[i] = (state[i] != IDLE);
`ifdef TS_TIMER_PERIODIC_EN
         req[i]  = (state[i] == PENDING) || pend[i];
`else
         req[i]  = (state[i] == PENDING);
`endif
      end
   end

   rr_arbiter #(.N(NUM_SLOTS), .ID_W(ID_W)) u_arb (
      .req       (req),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (win_idx),
      .grant_any (win_any)
   );

   // Per-slot state: arm beats cancel, cancel beats load, load beats expiry.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (rst) begin
            // NOTE: the slot tables are plain flop arrays with defined reset
            // values, so they are cleared along with the control state.
            state[i]    <= IDLE;
            deadline[i] <= '0;
            exp_ts[i]   <= '0;
`ifdef TS_TIMER_PERIODIC_EN
            periodic[i]  <= 1'b0;
            period[i]    <= '0;
            pend[i]      <= 1'b0;
            overrun_q[i] <= 1'b0;
`endif
         end else if (arm_valid && arm_id == ID_W'(i)) begin
            state[i]    <= ARMED;
            deadline[i] <= timestamp + delay_c;
`ifdef TS_TIMER_PERIODIC_EN
            periodic[i]  <= arm_periodic;
            period[i]    <= (delay_c == '0) ? TS_W'(1) : delay_c;
            pend[i]      <= 1'b0;
            overrun_q[i] <= 1'b0;
`endif
         end else if (cancel_valid && cancel_id == ID_W'(i)) begin
            state[i] <= IDLE;
`ifdef TS_TIMER_PERIODIC_EN
            pend[i]      <= 1'b0;
            overrun_q[i] <= 1'b0;
`endif
`ifdef TS_TIMER_PERIODIC_EN
         end else if (state[i] == ARMED && periodic[i]
                      && ts_expired(timestamp, deadline[i])) begin
            // Drift-free reload; a new expiry overrides a same-edge load.
            deadline[i] <= deadline[i] + period[i];
            exp_ts[i]   <= timestamp;
            pend[i]     <= 1'b1;
            if (pend[i] && !(take && grant[i]))
               overrun_q[i] <= 1'b1;
         end else if (take && grant[i]) begin
            if (periodic[i])
               pend[i] <= 1'b0;
            else
               state[i] <= IDLE;
`else
         end else if (take && grant[i]) begin
            state[i] <= IDLE;
`endif
         end else if (state[i] == ARMED && ts_expired(timestamp, deadline[i])) begin
            state[i]  <= PENDING;
            exp_ts[i] <= timestamp;
         end
      end
   end

   // Output register and round-robin pointer; a loaded event is committed.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid     <= 1'b0;
         evt_id        <= '0;
         evt_timestamp <= '0;
         rr_ptr        <= '0;
      end else if (!evt_valid || evt_ready) begin
         evt_valid <= win_any;
         if (win_any) begin
            evt_id        <= win_idx;
            evt_timestamp <= exp_ts[win_idx];
            rr_ptr        <= (win_idx == ID_W'(NUM_SLOTS - 1)) ? '0 : win_idx + ID_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ts_timer_scheduler.sv
// Directed bench for ts_timer_scheduler (NUM_SLOTS = 4).
module tb_ts_timer_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] timestamp;
   logic        arm_valid;
   logic        arm_ready;
   logic [1:0]  arm_id;
   logic [23:0] arm_delay;
   logic        cancel_valid;
   logic [1:0]  cancel_id;
   logic        evt_valid;
   logic        evt_ready;
   logic [1:0]  evt_id;
   logic [23:0] evt_timestamp;
   logic [3:0]  busy;
`ifdef TS_TIMER_PERIODIC_EN
   logic        arm_periodic;
   logic [3:0]  overrun;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ts_timer_scheduler #(.NUM_SLOTS(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .timestamp     (timestamp),
      .arm_valid     (arm_valid),
      .arm_ready     (arm_ready),
      .arm_id        (arm_id),
      .arm_delay     (arm_delay),
`ifdef TS_TIMER_PERIODIC_EN
      .arm_periodic  (arm_periodic),
      .overrun       (overrun),
`endif
      .cancel_valid  (cancel_valid),
      .cancel_id     (cancel_id),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .evt_id        (evt_id),
      .evt_timestamp (evt_timestamp),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input int id, input logic [23:0] d);
      arm_valid = 1'b1;
      arm_id    = 2'(id);
      arm_delay = d;
      step();
      arm_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      logic [23:0] wrap_ts [5];
      wrap_ts = '{24'hFFFFFF, 24'h000000, 24'h000001, 24'h000002, 24'h000003};

      rst          = 1'b1;
      timestamp    = 24'd0;
      arm_valid    = 1'b0;
      arm_id       = 2'd0;
      arm_delay    = 24'd0;
      cancel_valid = 1'b0;
      cancel_id    = 2'd0;
      evt_ready    = 1'b1;
`ifdef TS_TIMER_PERIODIC_EN
      arm_periodic = 1'b0;
`endif

      // Reset state
      step();
      step();
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_id", evt_id, 0);
      check("rst_evt_ts", evt_timestamp, 0);
      check("rst_busy", busy, 0);
      check("rst_arm_ready", arm_ready, 0);
      rst = 1'b0;
      #1;
      check("arm_ready_run", arm_ready, 1);

      // Delay 0 at ts 100: PENDING after one edge, event after two
      timestamp = 24'd100;
      arm(0, 24'd0);
      check("d0_busy_armed", busy, 4'b0001);
      check("d0_no_evt_e0", evt_valid, 0);
      step();
      check("d0_no_evt_e1", evt_valid, 0);
      step();
      check("d0_evt", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'd0, 24'd100});
      check("d0_busy_cleared", busy, 4'b0000);
      step();
      check("d0_consumed", evt_valid, 0);

      // Wrap: deadline 0xFFFFFE + 5 = 0x000003
      timestamp = 24'hFFFFFE;
      arm(1, 24'd5);
      for (int k = 0; k < 5; k++) begin
         timestamp = wrap_ts[k];
         step();
         check("wrap_no_early_evt", evt_valid, 0);
      end
      step();
      check("wrap_evt", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'd1, 24'h000003});
      step();

      // Four slots, same deadline, stalled consumer then drain
      do_reset();
      evt_ready = 1'b0;
      timestamp = 24'd200;
      for (int s = 0; s < 4; s++) arm(s, 24'd4);
      timestamp = 24'd204;
      step();
      step();
      check("rr_first", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'd0, 24'd204});
      check("rr_busy_after_load", busy, 4'b1110);
      for (int k = 0; k < 10; k++) begin
         step();
         check("rr_stall_stable", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'd0, 24'd204});
      end
      evt_ready = 1'b1;
      for (int s = 1; s < 4; s++) begin
         step();
         check("rr_b2b", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'(s), 24'd204});
      end
      step();
      check("rr_drained", evt_valid, 0);

      // Cancel at +4 us suppresses the event
      timestamp = 24'd300;
      arm(2, 24'd10);
      for (int t = 301; t <= 304; t++) begin
         timestamp    = 24'(t);
         cancel_valid = (t == 304);
         cancel_id    = 2'd2;
         step();
      end
      cancel_valid = 1'b0;
      check("cancel_busy", busy[2], 0);
      seen = 0;
      for (int t = 305; t < 320; t++) begin
         timestamp = 24'(t);
         step();
         if (evt_valid) seen++;
      end
      check("cancel_no_evt", seen, 0);

      // Arm and cancel same slot, same cycle: arm wins
      timestamp    = 24'd320;
      arm_valid    = 1'b1;
      arm_id       = 2'd2;
      arm_delay    = 24'd3;
      cancel_valid = 1'b1;
      cancel_id    = 2'd2;
      step();
      arm_valid    = 1'b0;
      cancel_valid = 1'b0;
      check("armcancel_busy", busy[2], 1);
      timestamp = 24'd323;
      step();
      step();
      check("armcancel_evt", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'd2, 24'd323});
      step();

      // Re-arm a PENDING slot discards its pending event
      evt_ready = 1'b0;
      timestamp = 24'd400;
      arm(0, 24'd0);
      arm(3, 24'd0);
      step();
      step();
      check("rearm_pending", {evt_valid, evt_id, busy}, {1'b1, 2'd0, 4'b1000});
      arm(3, 24'd50);
      check("rearm_held", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'd0, 24'd400});
      evt_ready = 1'b1;
      step();
      check("rearm_no_stale_evt", evt_valid, 0);
      seen = 0;
      for (int t = 420; t < 450; t += 10) begin
         timestamp = 24'(t);
         step();
         if (evt_valid) seen++;
      end
      timestamp = 24'd449;
      step();
      if (evt_valid) seen++;
      check("rearm_no_early", seen, 0);
      timestamp = 24'd450;
      step();
      step();
      check("rearm_evt", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'd3, 24'd450});
      step();

      // Delay clamp: 0xFFFFFF -> 0x7FFFFF, deadline 0x80000F
      timestamp = 24'h000010;
      arm(1, 24'hFFFFFF);
      seen = 0;
      timestamp = 24'h000011;
      step();
      if (evt_valid) seen++;
      step();
      if (evt_valid) seen++;
      timestamp = 24'h80000E;
      step();
      if (evt_valid) seen++;
      check("clamp_no_early", seen, 0);
      timestamp = 24'h80000F;
      step();
      step();
      check("clamp_evt", {evt_valid, evt_id, evt_timestamp}, {1'b1, 2'd1, 24'h80000F});
      step();

      // Reset mid-operation drops held and pending events
      evt_ready = 1'b0;
      timestamp = 24'd500;
      arm(2, 24'd0);
      arm(1, 24'd0);
      step();
      check("midrst_pre", {evt_valid, evt_id}, {1'b1, 2'd2});
      rst = 1'b1;
      step();
      check("midrst_out", {evt_valid, evt_id, evt_timestamp}, {1'b0, 2'd0, 24'd0});
      check("midrst_busy", busy, 0);
      check("midrst_arm_ready", arm_ready, 0);
      rst       = 1'b0;
      evt_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (evt_valid) seen++;
      end
      check("midrst_dropped", seen, 0);

`ifdef TS_TIMER_PERIODIC_EN
      begin
         logic [23:0] ev_q [$];
         do_reset();
         timestamp    = 24'd0;
         arm_periodic = 1'b1;
         arm(0, 24'd10);
         arm_periodic = 1'b0;
         for (int t = 1; t <= 35; t++) begin
            timestamp = 24'(t);
            step();
            if (evt_valid) ev_q.push_back(evt_timestamp);
         end
         check("per_count", ev_q.size(), 3);
         for (int k = 0; k < ev_q.size() && k < 3; k++)
            check("per_evt_ts", ev_q[k], 24'(10 * (k + 1)));
         evt_ready = 1'b0;
         for (int t = 36; t <= 65; t++) begin
            timestamp = 24'(t);
            step();
         end
         check("per_overrun", overrun, 4'b0001);
         check("per_held", {evt_valid, evt_timestamp}, {1'b1, 24'd40});
         evt_ready = 1'b1;
         timestamp = 24'd66;
         step();
         check("per_coalesced", {evt_valid, evt_timestamp}, {1'b1, 24'd60});
         timestamp = 24'd67;
         step();
         check("per_single", evt_valid, 0);
         cancel_valid = 1'b1;
         cancel_id    = 2'd0;
         step();
         cancel_valid = 1'b0;
         check("per_cancel_clr", {overrun, busy}, {4'b0000, 4'b0000});
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
